freq_sel_ctrl: RTL and testbench
================================

Name: freq_sel_ctrl

Overview:
Upstream control stage for the clock divider: converts two raw push-buttons (up/down) into the 2-bit divide selector that the divider consumes on its selector_i input. Each button is synchronised, debounced, and turned into a single press event. The events step a registered selector value with wrap or saturate behaviour, and a one-cycle change strobe accompanies each update.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a press or a release; legal range 2..65535.
WRAP, 1, 1 = selector wraps (3->0 on up, 0->3 on down); 0 = selector saturates at 0 and 3.
RESET_SEL, 2'b00, selector_o value after reset.

Ports:
clk_i  input  1  system clock; single clock domain, all flops on posedge.
rst_i  input  1  reset, asynchronous, active-high.
btn_up_i  input  1  raw asynchronous up button, active-high.
btn_down_i  input  1  raw asynchronous down button, active-high.
selector_o  output  2  registered divide selector, drives the divider's selector_i.
sel_change_o  output  1  one-cycle pulse, high in the cycle selector_o holds a new value.

Behaviour:
- Reset (async assert, sync release): selector_o=RESET_SEL, sel_change_o=0. Sync flops=0, FSMs=IDLE, counters=0, press events=0.
- Reset mid-debounce or mid-press: all in-progress state is discarded. A button still held at reset release must pass a full new press qualification before it counts.
- Synchronisation: each button goes through a 2-flop synchroniser. The output of the second flop is s.
- Per-button FSM, identical for up and down; counter width is ceil(log2(DEBOUNCE_CYCLES)):
  IDLE: if s=1, go to CHK_PRESS and set cnt=0.
  CHK_PRESS: if s=0, return to IDLE (glitch rejected, no event). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and set the press event register to 1 for exactly one cycle. Otherwise increment cnt.
  PRESSED: if s=0, go to CHK_REL and set cnt=0.
  CHK_REL: if s=1, return to PRESSED (no new event). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Otherwise increment cnt.
- Exactly one event per accepted press; holding the button produces no auto-repeat.
- Latency: the raw button is first sampled high at edge 0 and held. The event register is high during the cycle after edge DEBOUNCE_CYCLES+2. selector_o and sel_change_o update at edge DEBOUNCE_CYCLES+3.
- Selector update, on the edge after the events, with up_evt/dn_evt taken together:
  up only: WRAP=1 gives sel+1 mod 4. WRAP=0 gives min(sel+1,3).
  down only: WRAP=1 gives sel-1 mod 4. WRAP=0 gives max(sel-1,0).
  both in the same cycle: no change, no strobe (the events cancel).
  none: hold.
- sel_change_o=1 for one cycle only when selector_o actually changes value. A saturated up at 3 or down at 0 with WRAP=0 gives no strobe.
- selector_o is glitch-free and registered, so the divider may use it combinationally.

Test Plan:
1. DEBOUNCE_CYCLES=4, WRAP=1, RESET_SEL=0: hold btn_up_i high from edge 0 -> selector_o 0->1 at edge 7, sel_change_o high one cycle, no further change while held 50 cycles.
2. btn_up_i pulse high 3 cycles (< qualification) -> no event; selector_o stays 0, sel_change_o never high.
3. WRAP=1, starting at 3: one debounced up -> 0. Then one down -> 3. Each step gives exactly one strobe.
4. WRAP=0, starting at 3: up press -> stays 3, no strobe. Three down presses -> 2,1,0, then a fourth -> stays 0, no strobe.
5. Up and down raised on the same edge with identical stimulus -> both events in the same cycle; selector unchanged, no strobe.
6. Assert rst_i mid CHK_PRESS with the button held, release reset, keep holding -> selector_o=RESET_SEL immediately on assert; event only DEBOUNCE_CYCLES+3 edges after reset release.

Source files
------------

// File: rtl/freq_sel_ctrl.sv
// -----------------------------------------------------------------------------
// freq_sel_ctrl
//   Converts two raw push-buttons (up/down) into the registered 2-bit divide
//   selector for the clock divider. Each button is synchronised, debounced and
//   reduced to a single one-cycle press event. The events step the selector
//   with wrap or saturate behaviour, and a one-cycle strobe marks each change.
//
// Ports
//   clk_i         system clock, all flops on posedge
//   rst_i         asynchronous, active-high reset
//   btn_up_i      raw asynchronous up button, active-high
//   btn_down_i    raw asynchronous down button, active-high
//   selector_o    registered divide selector (glitch-free)
//   sel_change_o  one-cycle pulse in the first cycle selector_o holds a new value
//
// Contains freq_sel_debounce (per-button synchroniser + debounce FSM) and the
// top module freq_sel_ctrl.
// -----------------------------------------------------------------------------

// Per-button synchroniser and debounce FSM.
//   clk_i  clock
//   rst_i  asynchronous, active-high reset
//   btn_i  raw asynchronous button
//   evt_o  registered one-cycle press event
module freq_sel_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic evt_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_evt;

    logic w_s;
    assign w_s   = r_sync2;
    assign evt_o = r_evt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_evt   <= 1'b0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            // The event is a single-cycle pulse; only the CHK_PRESS -> PRESSED
            // transition raises it.
            r_evt   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= CHK_PRESS;
                        r_cnt   <= '0;
                    end
                end
                CHK_PRESS: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRESSED;
                        r_evt   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_s) begin
                        r_state <= CHK_REL;
                        r_cnt   <= '0;
                    end
                end
                CHK_REL: begin
                    // Bounce back to PRESSED without a new event: a held
                    // button never auto-repeats.
                    if (w_s) begin
                        r_state <= PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

module freq_sel_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter bit         WRAP            = 1'b1,
    parameter logic [1:0] RESET_SEL       = 2'b00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    output logic [1:0] selector_o,
    output logic       sel_change_o
);

    logic       w_up_evt;
    logic       w_dn_evt;
    logic [1:0] w_sel_next;
    logic [1:0] r_sel;
    logic       r_chg;

    freq_sel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_up_i),
        .evt_o (w_up_evt)
    );

    freq_sel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_down_i),
        .evt_o (w_dn_evt)
    );

    // Simultaneous up and down events cancel; 2-bit arithmetic gives the
    // mod-4 wrap for free.
    always_comb begin
        w_sel_next = r_sel;
        case ({w_up_evt, w_dn_evt})
            2'b10: begin
                if (WRAP || (r_sel != 2'd3)) w_sel_next = r_sel + 2'd1;
            end
            2'b01: begin
                if (WRAP || (r_sel != 2'd0)) w_sel_next = r_sel - 2'd1;
            end
            default: w_sel_next = r_sel;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sel <= RESET_SEL;
            r_chg <= 1'b0;
        end else begin
            r_sel <= w_sel_next;
            // Strobe only on a real value change, so saturated steps are silent.
            r_chg <= (w_sel_next != r_sel);
        end
    end

    assign selector_o   = r_sel;
    assign sel_change_o = r_chg;

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_sel_ctrl
//   Two instances share clock, reset and buttons: one wrapping from reset value
//   0, one saturating from reset value 3. Press tasks update a reference model
//   and push each expected new selector value into a per-instance queue; a
//   monitor pops and compares on every change strobe.
// -----------------------------------------------------------------------------
module tb_freq_sel_ctrl;

    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic [1:0] sel_w;
    logic       chg_w;
    logic [1:0] sel_s;
    logic       chg_s;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int strobe_cyc_w = 0;
    int t_press = 0;
    int m_w;
    int m_s;

    logic [1:0] exp_w_q[$];
    logic [1:0] exp_s_q[$];

    freq_sel_ctrl #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b1), .RESET_SEL(2'd0)) dut_w (
        .clk_i        (clk),
        .rst_i        (rst),
        .btn_up_i     (btn_up),
        .btn_down_i   (btn_dn),
        .selector_o   (sel_w),
        .sel_change_o (chg_w)
    );

    freq_sel_ctrl #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b0), .RESET_SEL(2'd3)) dut_s (
        .clk_i        (clk),
        .rst_i        (rst),
        .btn_up_i     (btn_up),
        .btn_down_i   (btn_dn),
        .selector_o   (sel_s),
        .sel_change_o (chg_s)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_step(input bit up, input bit dn);
        int nw;
        int ns;
        nw = m_w;
        ns = m_s;
        if (up && !dn) begin
            nw = (m_w + 1) % 4;
            ns = (m_s == 3) ? 3 : m_s + 1;
        end else if (dn && !up) begin
            nw = (m_w + 3) % 4;
            ns = (m_s == 0) ? 0 : m_s - 1;
        end
        if (nw != m_w) exp_w_q.push_back(nw[1:0]);
        if (ns != m_s) exp_s_q.push_back(ns[1:0]);
        m_w = nw;
        m_s = ns;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (chg_w) begin
                if (exp_w_q.size() == 0) chk("unexp_strobe_w", 1, 0);
                else chk("strobe_sel_w", int'(sel_w), int'(exp_w_q.pop_front()));
                strobe_cyc_w = cyc;
            end
            if (chg_s) begin
                if (exp_s_q.size() == 0) chk("unexp_strobe_s", 1, 0);
                else chk("strobe_sel_s", int'(sel_s), int'(exp_s_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // A raw high held for n edges gives n synchronised samples; a press needs
    // DEB+1 of them (the IDLE sample plus DEB qualification samples).
    task automatic press(input bit up, input bit dn, input int hold);
        @(negedge clk);
        btn_up  = up;
        btn_dn  = dn;
        t_press = cyc;
        if (hold >= DEB + 1) model_step(up, dn);
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic settle_check(input string tag);
        for (int i = 0; i < 100 && (exp_w_q.size() != 0 || exp_s_q.size() != 0); i++)
            @(negedge clk);
        chk({tag, "_pending_w"}, exp_w_q.size(), 0);
        chk({tag, "_pending_s"}, exp_s_q.size(), 0);
        chk({tag, "_sel_w"}, int'(sel_w), m_w);
        chk({tag, "_sel_s"}, int'(sel_s), m_s);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        btn_up = 1'b0;
        btn_dn = 1'b0;
        rst    = 1'b1;
        m_w    = 0;
        m_s    = 3;
        repeat (2) @(negedge clk);
        chk("rst_sel_w", int'(sel_w), 0);
        chk("rst_sel_s", int'(sel_s), 3);
        chk("rst_chg_w", int'(chg_w), 0);
        chk("rst_chg_s", int'(chg_s), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Held up press: one step, fixed latency, no repeat while held.
        strobe_cyc_w = 0;
        press(1'b1, 1'b0, 50);
        chk("latency_press", strobe_cyc_w - t_press, DEB + 4);
        settle_check("hold_up");

        // Short pulses below qualification, then the first qualifying length.
        press(1'b1, 1'b0, 3);
        settle_check("pulse3");
        press(1'b1, 1'b0, DEB);
        settle_check("pulse_deb");
        press(1'b1, 1'b0, DEB + 1);
        settle_check("pulse_deb_p1");

        // Wrap 3 -> 0 on up and 0 -> 3 on down.
        press(1'b1, 1'b0, 10 + $urandom_range(0, 5));
        settle_check("up_to3");
        press(1'b1, 1'b0, 10 + $urandom_range(0, 5));
        settle_check("wrap_up");
        press(1'b0, 1'b1, 10 + $urandom_range(0, 5));
        settle_check("wrap_dn");

        // Down presses walk the saturating instance to 0 and hold it there.
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 1'b1, 8 + $urandom_range(0, 10));
            settle_check("dn_walk");
        end

        // Both buttons together cancel.
        press(1'b1, 1'b1, 12);
        settle_check("both");

        // Reset while mid-qualification with the button held.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_sel_w", int'(sel_w), 0);
        chk("midrst_sel_s", int'(sel_s), 3);
        chk("midrst_chg_w", int'(chg_w), 0);
        exp_w_q.delete();
        exp_s_q.delete();
        m_w = 0;
        m_s = 3;
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        t_press      = cyc;
        strobe_cyc_w = 0;
        model_step(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        btn_up = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        chk("latency_rst", strobe_cyc_w - t_press, DEB + 4);
        settle_check("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
